// File: rtl/rv32i_types.sv
// Shared rv32i pipeline types: forwarding mux selects and hazard sequencer states.
package rv32i_types;

    localparam logic [4:0] REG_X0 = 5'd0;

    typedef enum logic [1:0] {
        rs_out  = 2'b00,
        regfile = 2'b01,
        alu_out = 2'b10
    } forwardmux_t;

    typedef enum logic [1:0] {
        RUN,
        MEM_WAIT,
        LU_BUBBLE
    } hazard_state_t;

endpackage

// File: rtl/fwd_unit.sv
// Execute-stage operand forwarding compare for one source register.
module fwd_unit
    import rv32i_types::*;
(
    input  logic [4:0]  ex_rs,
    input  logic [4:0]  mem_rd,
    input  logic        mem_regwrite,
    input  logic [4:0]  wb_rd,
    input  logic        wb_regwrite,
    output forwardmux_t sel
);

    always_comb begin
        // NOTE: assigning a default before any branch keeps this purely combinational; a missed path would infer a latch.
        sel = rs_out;
        if (mem_regwrite && (mem_rd != REG_X0) && (mem_rd == ex_rs)) begin
            sel = alu_out;
        end else if (wb_regwrite && (wb_rd != REG_X0) && (wb_rd == ex_rs)) begin
            sel = regfile;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencer for the 5-stage rv32i core: forwarding, load-use bubbles,
// cache-miss freeze, branch squash and stall/flush performance counters.
module hazard_ctrl
    import rv32i_types::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [4:0]       ex_rs1,
    input  logic [4:0]       ex_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_load,
    input  logic             ex_regwrite,
    input  logic             ex_branch,
    input  logic             ex_jump,
    input  logic             br_en,
    input  logic [4:0]       mem_rd,
    input  logic             mem_regwrite,
    input  logic [4:0]       wb_rd,
    input  logic             wb_regwrite,
    input  logic             icache_req,
    input  logic             icache_resp,
    input  logic             dcache_req,
    input  logic             dcache_resp,
    output logic [1:0]       forwardA,
    output logic [1:0]       forwardB,
    output logic             load_pc,
    output logic             load_if_id,
    output logic             load_id_ex,
    output logic             load_ex_mem,
    output logic             load_mem_wb,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic             pc_redirect,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    hazard_state_t state, state_next;
    forwardmux_t   fwd_a, fwd_b;

    logic mem_busy, load_use, redirect;
    logic ld_front, ld_id_ex, ld_back;
    logic fl_if_id, fl_id_ex, redir;

    fwd_unit u_fwd_rs1 (
        .ex_rs        (ex_rs1),
        .mem_rd       (mem_rd),
        .mem_regwrite (mem_regwrite),
        .wb_rd        (wb_rd),
        .wb_regwrite  (wb_regwrite),
        .sel          (fwd_a)
    );

    fwd_unit u_fwd_rs2 (
        .ex_rs        (ex_rs2),
        .mem_rd       (mem_rd),
        .mem_regwrite (mem_regwrite),
        .wb_rd        (wb_rd),
        .wb_regwrite  (wb_regwrite),
        .sel          (fwd_b)
    );

    assign mem_busy = (icache_req && !icache_resp) || (dcache_req && !dcache_resp);
    assign redirect = ex_jump || (ex_branch && br_en);
    assign load_use = ex_load && ex_regwrite && (ex_rd != REG_X0) &&
                      ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));

    // Every state resolves with RUN rules once memory is idle; LU_BUBBLE only
    // differs in that its EX slot is a bubble, so load_use is masked there.
    always_comb begin
        state_next = RUN;
        ld_front   = 1'b0;
        ld_id_ex   = 1'b0;
        ld_back    = 1'b0;
        fl_if_id   = 1'b0;
        fl_id_ex   = 1'b0;
        redir      = 1'b0;
        if (mem_busy) begin
            state_next = MEM_WAIT;
        end else if (redirect) begin
            ld_front = 1'b1;
            ld_id_ex = 1'b1;
            ld_back  = 1'b1;
            fl_if_id = 1'b1;
            fl_id_ex = 1'b1;
            redir    = 1'b1;
        end else if (load_use && (state != LU_BUBBLE)) begin
            state_next = LU_BUBBLE;
            ld_id_ex   = 1'b1;
            fl_id_ex   = 1'b1;
            ld_back    = 1'b1;
        end else begin
            ld_front = 1'b1;
            ld_id_ex = 1'b1;
            ld_back  = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= RUN;
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            state <= state_next;
            if (!(ld_front && ld_id_ex && ld_back) && (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + CNT_W'(1);
            end
            if (redir && (flush_count != '1)) begin
                flush_count <= flush_count + CNT_W'(1);
            end
        end
    end

    // Outputs are forced quiet for as long as reset is held, independent of the clock.
    assign forwardA    = rst ? 2'b00 : fwd_a;
    assign forwardB    = rst ? 2'b00 : fwd_b;
    assign load_pc     = ld_front && !rst;
    assign load_if_id  = ld_front && !rst;
    assign load_id_ex  = ld_id_ex && !rst;
    assign load_ex_mem = ld_back  && !rst;
    assign load_mem_wb = ld_back  && !rst;
    assign flush_if_id = fl_if_id && !rst;
    assign flush_id_ex = fl_id_ex && !rst;
    assign pc_redirect = redir    && !rst;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: a spec-level model pushes expected outputs, sampled mid-cycle.
module tb_hazard_ctrl;

    localparam int CNT_W = 32;

    logic clk = 1'b0;
    logic rst;
    logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
    logic id_use_rs1, id_use_rs2, ex_load, ex_regwrite, ex_branch, ex_jump, br_en;
    logic mem_regwrite, wb_regwrite, icache_req, icache_resp, dcache_req, dcache_resp;
    logic [1:0] forwardA, forwardB;
    logic load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb;
    logic flush_if_id, flush_id_ex, pc_redirect;
    logic [CNT_W-1:0] stall_cycles, flush_count;

    always #5 clk = ~clk;

    hazard_ctrl #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_load(ex_load),
        .ex_regwrite(ex_regwrite), .ex_branch(ex_branch), .ex_jump(ex_jump), .br_en(br_en),
        .mem_rd(mem_rd), .mem_regwrite(mem_regwrite), .wb_rd(wb_rd), .wb_regwrite(wb_regwrite),
        .icache_req(icache_req), .icache_resp(icache_resp),
        .dcache_req(dcache_req), .dcache_resp(dcache_resp),
        .forwardA(forwardA), .forwardB(forwardB),
        .load_pc(load_pc), .load_if_id(load_if_id), .load_id_ex(load_id_ex),
        .load_ex_mem(load_ex_mem), .load_mem_wb(load_mem_wb),
        .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex), .pc_redirect(pc_redirect),
        .stall_cycles(stall_cycles), .flush_count(flush_count)
    );

    typedef struct {
        string       tag;
        logic [11:0] ctrl;
        logic [31:0] stall;
        logic [31:0] flush;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Reference model state: 0 = running, 1 = waiting on memory, 2 = bubble cycle.
    int          m_state = 0;
    logic [31:0] m_stall = '0;
    logic [31:0] m_flush = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [1:0] m_fwd(input logic [4:0] rs);
        if (mem_regwrite && mem_rd != 0 && mem_rd == rs) return 2'b10;
        if (wb_regwrite && wb_rd != 0 && wb_rd == rs) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic m_busy();
        return (icache_req && !icache_resp) || (dcache_req && !dcache_resp);
    endfunction

    function automatic logic m_redirect();
        return ex_jump || (ex_branch && br_en);
    endfunction

    function automatic logic m_lu();
        return ex_load && ex_regwrite && ex_rd != 0 && m_state != 2 &&
               ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
    endfunction

    // ctrl = {fwdA, fwdB, pc, if_id, id_ex, ex_mem, mem_wb, fl_if_id, fl_id_ex, redirect}
    function automatic logic [11:0] m_ctrl();
        if (rst)          return 12'b0;
        if (m_busy())     return {m_fwd(ex_rs1), m_fwd(ex_rs2), 8'b0000_0000};
        if (m_redirect()) return {m_fwd(ex_rs1), m_fwd(ex_rs2), 8'b1111_1111};
        if (m_lu())       return {m_fwd(ex_rs1), m_fwd(ex_rs2), 8'b0011_1010};
        return {m_fwd(ex_rs1), m_fwd(ex_rs2), 8'b1111_1000};
    endfunction

    task automatic m_edge();
        if (rst) begin
            m_state = 0; m_stall = '0; m_flush = '0;
        end else if (m_busy()) begin
            m_state = 1; m_stall++;
        end else if (m_redirect()) begin
            m_state = 0; m_flush++;
        end else if (m_lu()) begin
            m_state = 2; m_stall++;
        end else begin
            m_state = 0;
        end
    endtask

    task automatic clear_inputs();
        {id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd} = '0;
        {id_use_rs1, id_use_rs2, ex_load, ex_regwrite, ex_branch, ex_jump, br_en} = '0;
        {mem_regwrite, wb_regwrite, icache_req, icache_resp, dcache_req, dcache_resp} = '0;
    endtask

    // Called just after a falling edge with inputs already applied.
    task automatic run_cycle(input string tag);
        exp_t e;
        e.tag   = tag;
        e.ctrl  = m_ctrl();
        e.stall = m_stall;
        e.flush = m_flush;
        sb_q.push_back(e);
        #2;
        e = sb_q.pop_front();
        check({e.tag, "/ctrl"}, 32'(
            {forwardA, forwardB, load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb,
             flush_if_id, flush_id_ex, pc_redirect}), 32'(e.ctrl));
        check({e.tag, "/stall"}, stall_cycles, e.stall);
        check({e.tag, "/flush"}, flush_count, e.flush);
        @(posedge clk);
        m_edge();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        @(negedge clk);
        run_cycle("reset");
        rst = 1'b0;
        run_cycle("idle");

        // Forwarding priority and x0 handling
        ex_rs1 = 5'd1; ex_rs2 = 5'd2;
        mem_regwrite = 1'b1; mem_rd = 5'd1; wb_regwrite = 1'b1; wb_rd = 5'd1;
        run_cycle("fwd_mem_prio");
        mem_rd = 5'd0;
        run_cycle("fwd_wb");
        ex_rs1 = 5'd7; ex_rs2 = 5'd0; wb_rd = 5'd0;
        run_cycle("fwd_x0");
        ex_rs2 = 5'd9; wb_rd = 5'd9; mem_rd = 5'd9; mem_regwrite = 1'b0;
        run_cycle("fwd_b_wb");
        clear_inputs();

        // Load-use: lw x5 in EX, consumer in ID reads x5
        ex_load = 1'b1; ex_regwrite = 1'b1; ex_rd = 5'd5;
        id_use_rs2 = 1'b1; id_rs2 = 5'd5;
        run_cycle("lu_hold");
        ex_load = 1'b0; ex_regwrite = 1'b0; ex_rd = 5'd0;
        mem_regwrite = 1'b1; mem_rd = 5'd5;
        run_cycle("lu_bubble");
        id_use_rs2 = 1'b0; id_rs2 = 5'd0;
        mem_regwrite = 1'b0; mem_rd = 5'd0;
        wb_regwrite = 1'b1; wb_rd = 5'd5; ex_rs2 = 5'd5;
        run_cycle("lu_consume");
        clear_inputs();

        // Taken/not-taken branches and jumps
        ex_branch = 1'b1; br_en = 1'b0;
        run_cycle("br_not_taken");
        br_en = 1'b1;
        run_cycle("br_taken");
        ex_load = 1'b1; ex_regwrite = 1'b1; ex_rd = 5'd3; id_use_rs1 = 1'b1; id_rs1 = 5'd3;
        run_cycle("br_over_lu");
        clear_inputs();
        ex_jump = 1'b1;
        run_cycle("jump");
        clear_inputs();

        // Data-cache miss for 4 cycles with a taken branch waiting in EX
        dcache_req = 1'b1; ex_branch = 1'b1; br_en = 1'b1;
        for (int i = 0; i < 4; i++) run_cycle($sformatf("dmiss%0d", i));
        dcache_resp = 1'b1;
        run_cycle("dmiss_resp");
        clear_inputs();
        run_cycle("after_dmiss");

        // Instruction-cache miss, then async reset in the middle of MEM_WAIT
        icache_req = 1'b1;
        run_cycle("imiss0");
        run_cycle("imiss1");
        #1 rst = 1'b1;
        #1 check("async_rst/load_pc", 32'(load_pc), 32'd0);
        check("async_rst/stall", stall_cycles, 32'd0);
        m_state = 0; m_stall = '0; m_flush = '0;
        @(negedge clk);
        run_cycle("rst_held");
        clear_inputs();
        rst = 1'b0;
        run_cycle("rst_release");
        ex_jump = 1'b1;
        run_cycle("post_rst_jump");
        clear_inputs();
        run_cycle("final_idle");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline sequencer for the 5-stage rv32i core. Drives the execute-stage forwarding selects (forwardA/forwardB), and the per-stage register load/flush enables.
- Inserts load-use bubbles, freezes the pipeline on cache misses, and squashes wrong-path instructions on taken branches/jumps.
- Keeps stall/flush performance counters.

Parameters:
CNT_W, 32, width of performance counters

Ports:
clk  in  1  core clock
rst  in  1  asynchronous active-high reset
id_rs1  in  5  rs1 of instruction in ID
id_rs2  in  5  rs2 of instruction in ID
id_use_rs1  in  1  ID instruction reads rs1
id_use_rs2  in  1  ID instruction reads rs2
ex_rs1  in  5  rs1 of instruction in EX
ex_rs2  in  5  rs2 of instruction in EX
ex_rd  in  5  destination in EX
ex_load  in  1  EX instruction is a load
ex_regwrite  in  1  EX writes regfile
ex_branch  in  1  EX instruction is a conditional branch
ex_jump  in  1  EX instruction is jal/jalr
br_en  in  1  compare result from execute stage
mem_rd  in  5  destination in MEM
mem_regwrite  in  1  MEM writes regfile
wb_rd  in  5  destination in WB
wb_regwrite  in  1  WB writes regfile
icache_req  in  1  fetch request outstanding
icache_resp  in  1  fetch data valid
dcache_req  in  1  MEM-stage load/store outstanding
dcache_resp  in  1  data access complete
forwardA  out  2  00 rs1_out, 01 regfilemux_out (WB), 10 ex_alu_out (MEM)
forwardB  out  2  same encoding for rs2
load_pc  out  1  PC register enable
load_if_id  out  1  IF/ID enable
load_id_ex  out  1  ID/EX enable
load_ex_mem  out  1  EX/MEM enable
load_mem_wb  out  1  MEM/WB enable
flush_if_id  out  1  IF/ID loads bubble
flush_id_ex  out  1  ID/EX loads bubble
pc_redirect  out  1  PC mux selects EX target
stall_cycles  out  CNT_W  cycles spent in MEM_WAIT or LU_BUBBLE
flush_count  out  CNT_W  taken redirects

Behaviour:
- Reset (async, any time):
  - state = RUN; counters = 0.
  - All load_* = 0, flush_* = 0, pc_redirect = 0, forwardA/B = 00, held while rst is high.
  - First enables assert the cycle after rst falls.
- Forwarding (combinational, per operand X in {rs1, rs2}):
  - 10 if mem_regwrite && mem_rd != 0 && mem_rd == ex_X.
  - Else 01 if wb_regwrite && wb_rd != 0 && wb_rd == ex_X.
  - Else 00.
  - MEM has priority over WB. x0 never forwards.
- mem_busy = (icache_req && !icache_resp) || (dcache_req && !dcache_resp).
- load_use = ex_load && ex_regwrite && ex_rd != 0 && ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd)).
- redirect = ex_jump || (ex_branch && br_en).
- FSM states: RUN, MEM_WAIT, LU_BUBBLE. Priority at each edge is mem_busy > redirect > load_use.
- RUN:
  - No events: all load_* = 1.
  - mem_busy: all load_* = 0 this cycle, next state MEM_WAIT. Redirect is not taken while frozen; EX is held, so br_en stays valid.
  - redirect (not busy):
    - all load_* = 1, pc_redirect = 1, flush_if_id = flush_id_ex = 1.
    - flush_count += 1 (saturating).
    - Any coincident load_use is ignored, because the ID instruction is squashed.
  - load_use (not busy, no redirect):
    - load_pc = load_if_id = 0 (hold).
    - load_id_ex = 1 with flush_id_ex = 1 (bubble).
    - load_ex_mem = load_mem_wb = 1.
    - Next state LU_BUBBLE.
- MEM_WAIT:
  - All load_* = 0 while mem_busy.
  - When mem_busy drops, evaluate as RUN in the same cycle (no extra dead cycle) and leave per RUN rules.
- LU_BUBBLE:
  - Exactly one cycle. The load is now in MEM and the consumer stays in ID.
  - Evaluate as RUN. load_use cannot re-fire, because EX now holds a bubble.
  - Next state is RUN, or MEM_WAIT if busy.
- stall_cycles increments (saturating at all-ones) on every cycle where any load_* is 0.
- Flush and load are both registered by the stage registers at the same edge. Flush wins over captured data.

Decomposition:
- rv32i_types package additions:
  - forwardmux enum (rs_out = 2'b00, regfile = 2'b01, alu_out = 2'b10).
  - hazard_state_t enum {RUN, MEM_WAIT, LU_BUBBLE}.
- One sub-module, fwd_unit: purely combinational forwarding compare, instantiated twice (rs1, rs2).

Test Plan:
- add x1 (MEM) with ex_rs1 = 1, and add x1 in WB → forwardA = 10. Repeat with mem_rd = 0 → forwardA = 01 (WB match).
- lw x5 in EX, ID add reads x5 → one cycle: load_pc = load_if_id = 0, flush_id_ex = 1, state LU_BUBBLE. Next cycle: all loads = 1; consumer in EX sees forward = 01; stall_cycles = 1.
- beq taken (br_en = 1) in EX, no busy → pc_redirect = 1, flush_if_id = flush_id_ex = 1, flush_count = 1. Same with simultaneous load_use → still no hold; load_pc = 1.
- dcache_req with resp after 4 cycles, plus a taken branch in EX → all load_* = 0 for 4 cycles, then redirect on the resp cycle; stall_cycles = 4.
- Assert rst mid-MEM_WAIT → outputs zero immediately (async), counters = 0, state RUN after release.
- Write to x0 in MEM with ex_rs2 = 0 → forwardB = 00.
